// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_F, ARB_HOLD_D} arb_state_t;
  typedef enum logic {GNT_F, GNT_D} grant_t;
  localparam int IMEM_DEPTH_WORDS = 2048;
  localparam int IMEM_IDX_W = 11;
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch/debug request-response channels plus the imem read port
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic f_req_valid;
  logic f_req_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic f_rsp_valid;
  logic f_rsp_ready;
  logic [DATA_W-1:0] f_rsp_data;
  logic f_rsp_err;
  logic d_req_valid;
  logic d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic d_rsp_valid;
  logic d_rsp_ready;
  logic [DATA_W-1:0] d_rsp_data;
  logic d_rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic busy;
  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    input  mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_addr, busy
  );
  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    output mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_addr, busy
  );
endinterface

// File: rtl/imem_rr_pick.sv
// imem_rr_pick: combinational 2-way round-robin picker, grant[0]=F, grant[1]=D
module imem_rr_pick
  import imem_arb_pkg::*;
(
  input  logic       f_valid,
  input  logic       d_valid,
  input  grant_t     last_grant,
  input  logic       slot_free,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = slot_free && f_valid && (!d_valid || last_grant == GNT_D);
    grant[1] = slot_free && d_valid && (!f_valid || last_grant == GNT_F);
  end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares imem between fetch and debug; IMEM_ARB_ERR_EN enables misaligned/out-of-range error responses
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
  input logic clk,
  input logic rst_n,
  imem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  arb_state_t state_q, state_d;
  grant_t last_q;
  logic [1:0] gnt;
  logic slot_free, accept, err;
  logic [ADDR_W-1:0] sel_addr, word_addr, addr_q;
  logic [DATA_W-1:0] f_data_q, d_data_q, cap_data;
  logic f_err_q, d_err_q;
  // a held response that is consumed this cycle frees the slot for a back-to-back accept
  assign slot_free = state_q == ARB_IDLE || (state_q == ARB_HOLD_F && bus.f_rsp_ready) || (state_q == ARB_HOLD_D && bus.d_rsp_ready);
  imem_rr_pick u_pick (
    .f_valid   (bus.f_req_valid),
    .d_valid   (bus.d_req_valid),
    .last_grant(last_q),
    .slot_free (slot_free),
    .grant     (gnt)
  );
  assign accept = |gnt;
  assign sel_addr = gnt[1] ? bus.d_req_addr : bus.f_req_addr;
  assign word_addr = ADDR_W'({sel_addr[IDX_W+1:2], 2'b00});
`ifdef IMEM_ARB_ERR_EN
  assign err = |sel_addr[1:0] || |(sel_addr >> (IDX_W + 2));
`else
  assign err = 1'b0;
`endif
  assign cap_data = err ? '0 : bus.mem_rdata;
  // outside an accept the registered address keeps the memory output stable
  assign bus.mem_addr = accept ? word_addr : addr_q;
  assign bus.f_req_ready = gnt[0];
  assign bus.d_req_ready = gnt[1];
  assign bus.f_rsp_valid = state_q == ARB_HOLD_F;
  assign bus.d_rsp_valid = state_q == ARB_HOLD_D;
  assign bus.f_rsp_data = f_data_q;
  assign bus.d_rsp_data = d_data_q;
  assign bus.f_rsp_err = f_err_q;
  assign bus.d_rsp_err = d_err_q;
  assign bus.busy = state_q != ARB_IDLE;
  always_comb begin
    state_d = gnt[0] ? ARB_HOLD_F : gnt[1] ? ARB_HOLD_D : slot_free ? ARB_IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= GNT_D;
      addr_q <= '0;
      f_data_q <= '0;
      d_data_q <= '0;
      f_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else if (accept) begin
      last_q <= gnt[0] ? GNT_F : GNT_D;
      addr_q <= word_addr;
      if (gnt[0]) begin
        f_data_q <= cap_data;
        f_err_q <= err;
      end else begin
        d_data_q <= cap_data;
        d_err_q <= err;
      end
    end
  end
endmodule
